booth_mac_accum: RTL

- Sequential dot-product accumulator directly downstream of the combinational Booth multiplier.
- Consumes a stream of signed 2*DATA_WIDTH products over a valid/ready handshake and sums a programmed number of them into a wider signed accumulator, saturating on overflow.
- Presents the finished sum on a valid/ready output port and holds it until it is taken.

---
 rtl/booth_mac_accum_if.sv | 30 +++
 rtl/booth_mac_accum.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/booth_mac_accum_if.sv
// Handshake bundle between the Booth multiplier stream, the accumulator
// and the result consumer. The master side drives requests and products;
// the slave side (the accumulator) returns ready, the result and status.
interface booth_mac_accum_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_LEN    = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
);
    logic                           start;
    logic [LEN_WIDTH-1:0]           len;
    logic                           prod_valid;
    logic                           prod_ready;
    logic signed [2*DATA_WIDTH-1:0] prod_data;
    logic                           acc_valid;
    logic                           acc_ready;
    logic signed [ACC_WIDTH-1:0]    acc_data;
    logic                           acc_overflow;
    logic                           busy;

    modport master (
        output start, len, prod_valid, prod_data, acc_ready,
        input  prod_ready, acc_valid, acc_data, acc_overflow, busy
    );

    modport slave (
        input  start, len, prod_valid, prod_data, acc_ready,
        output prod_ready, acc_valid, acc_data, acc_overflow, busy
    );
endinterface

// File: rtl/booth_mac_accum.sv
// Sequential dot-product accumulator placed after the combinational Booth
// multiplier. Sums a programmed number of signed products into a wider
// saturating accumulator and offers the result on a valid/ready port.
// Every output is driven straight from a register.
module booth_mac_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_LEN    = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mac_accum_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                       r_state;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [LEN_WIDTH-1:0]         r_count;
    logic [LEN_WIDTH-1:0]         r_len;
    logic                         r_prod_ready;
    logic                         r_acc_valid;
    logic                         r_overflow;
    logic                         r_busy;

    logic signed [SW-1:0]         w_prod_ext;
    logic signed [SW-1:0]         w_acc_ext;
    logic signed [SW-1:0]         w_sum;
    logic [LEN_WIDTH-1:0]         w_len_clamp;
    logic [LEN_WIDTH-1:0]         w_count_nxt;
    logic                         w_hs;

    // True when the one-bit-wider sum no longer fits the accumulator width.
    function automatic logic sat_ovf(input logic signed [SW-1:0] s);
        return s[SW-1] != s[SW-2];
    endfunction

    // Clamp the wide sum to the accumulator range; the extra top bit tells
    // which rail was crossed.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [SW-1:0] s);
        logic signed [ACC_WIDTH-1:0] v;
        if (s[SW-1] != s[SW-2]) begin
            if (s[SW-1]) begin
                v = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                v = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            v = s[ACC_WIDTH-1:0];
        end
        return v;
    endfunction

    // Both operands are widened by sign extension so the add cannot wrap.
    assign w_prod_ext  = {{(SW-PW){bus.prod_data[PW-1]}}, bus.prod_data};
    assign w_acc_ext   = {r_acc[ACC_WIDTH-1], r_acc};
    assign w_sum       = w_acc_ext + w_prod_ext;
    assign w_len_clamp = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
    assign w_count_nxt = r_count + LEN_WIDTH'(1);
    assign w_hs        = bus.prod_valid & r_prod_ready;

    assign bus.prod_ready   = r_prod_ready;
    assign bus.acc_valid    = r_acc_valid;
    assign bus.acc_data     = r_acc;
    assign bus.acc_overflow = r_overflow;
    assign bus.busy         = r_busy;

    // Control FSM with registered handshake/status outputs and the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_count      <= '0;
            r_len        <= '0;
            r_prod_ready <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Products are never accepted here, even alongside start.
                    if (bus.start) begin
                        r_acc      <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_len      <= w_len_clamp;
                        r_busy     <= 1'b1;
                        if (w_len_clamp == '0) begin
                            r_state     <= S_DONE;
                            r_acc_valid <= 1'b1;
                        end else begin
                            r_state      <= S_ACCUM;
                            r_prod_ready <= 1'b1;
                        end
                    end
                end

                S_ACCUM: begin
                    if (w_hs) begin
                        r_acc   <= sat_acc(w_sum);
                        r_count <= w_count_nxt;
                        if (sat_ovf(w_sum)) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_count_nxt == r_len) begin
                            r_state      <= S_DONE;
                            r_prod_ready <= 1'b0;
                            r_acc_valid  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // Result and overflow flag hold until the consumer takes them.
                    if (bus.acc_ready) begin
                        r_state     <= S_IDLE;
                        r_acc_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_prod_ready <= 1'b0;
                    r_acc_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule
